cnt_snapshot_mon: RTL and testbench



---
 rtl/cnt_mon_pkg.sv | 26 ++
 rtl/snap_fifo.sv | 124 ++++++++++++
 rtl/cnt_snapshot_mon.sv | 133 +++++++++++++
 tb/tb_cnt_snapshot_mon.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_mon_pkg.sv
// -----------------------------------------------------------------------------
// cnt_mon_pkg
// Shared types and defaults for the counter snapshot monitor (cnt_snapshot_mon)
// and its snapshot FIFO (snap_fifo).
//   cnt_t        : default-width counter / snapshot word
//   chk_state_e  : step-checker state encoding
//   is_pow2()    : elaboration-time helper used to validate DEPTH
// -----------------------------------------------------------------------------
package cnt_mon_pkg;

  localparam int CNT_WIDTH     = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    CHK_IDLE   = 2'd0,  // waiting for a first sample to use as the baseline
    CHK_TRACK  = 2'd1,  // comparing every sample against prev + STEP
    CHK_RESYNC = 2'd2   // one cycle re-baseline after a violation
  } chk_state_e;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage : cnt_mon_pkg

// File: rtl/snap_fifo.sv
// -----------------------------------------------------------------------------
// snap_fifo
// Generic DEPTH x WIDTH synchronous FIFO with a registered head word.
// Occupancy is kept in its own counter rather than derived from the pointers.
// clr has priority over push and pop and empties the FIFO.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous flush
//   push        : write push_data this cycle (ignored when full without pop)
//   push_data   : word to store
//   pop         : consume the head this cycle (ignored when empty)
//   out_valid   : head word valid
//   out_data    : registered head word
//   level       : occupancy, 0..DEPTH
//   full        : level == DEPTH
// -----------------------------------------------------------------------------
module snap_fifo
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_nxt;
  logic             head_load;
  logic             push_ok;
  logic             pop_ok;
  logic             is_full;
  logic             is_empty;

  assign is_full    = (count == LVL_FULL);
  assign is_empty   = (count == '0);
  // DEPTH is a power of two, so plain AW-bit increment wraps DEPTH-1 -> 0.
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  assign pop_ok  = pop  && !clr && !is_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && !clr && (!is_full || pop_ok);

  // Storage array. Only written entries are ever read, so it carries no reset.
  // NOTE: memories are left unreset on purpose; a reset here would force
  // the array into flops instead of RAM and buys nothing functionally.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Next head: the following stored entry after a pop, or the incoming word
  // when it lands in an empty FIFO (or replaces the only entry being popped).
  always_comb begin
    // NOTE: give every always_comb output a default first; a path that skips
    // the assignment would otherwise infer a latch.
    head_nxt  = head_q;
    head_load = 1'b0;
    if (pop_ok && (count > LVL_ONE)) begin
      head_nxt  = mem[rd_ptr_nxt];
      head_load = 1'b1;
    end else if (push_ok && (is_empty || (pop_ok && count == LVL_ONE))) begin
      head_nxt  = push_data;
      head_load = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (head_load) begin
        head_q <= head_nxt;
      end
    end
  end

  assign out_valid = !is_empty;
  assign out_data  = head_q;
  assign level     = count;
  assign full      = is_full;

endmodule : snap_fifo

// File: rtl/cnt_snapshot_mon.sv
// -----------------------------------------------------------------------------
// cnt_snapshot_mon
// Monitors a free-running counter: optionally checks that it advances by STEP
// every clock (modulo 2^WIDTH), and captures snapshots on request into a small
// FIFO drained over a valid/ready handshake.
//
// Optional feature: define CNT_SNAPSHOT_STEP_CHECK_EN to build the step
// checker (FSM + prev register). Without it step_err is tied low and the FIFO
// path is unchanged.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   cnt_in      : counter value from the upstream counter stage
//   capture     : sample cnt_in into the FIFO this cycle
//   clr         : synchronous flush of FIFO, sticky flags and checker
//   out_valid   : FIFO head valid
//   out_ready   : consumer accepts the head
//   out_data    : FIFO head snapshot (registered)
//   level       : occupancy, 0..DEPTH
//   full        : level == DEPTH
//   overflow    : sticky, a capture was dropped while full
//   step_err    : sticky, counter step violation seen
// -----------------------------------------------------------------------------
module cnt_snapshot_mon
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       cnt_in,
  input  logic                   capture,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic                   step_err
);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("cnt_snapshot_mon: DEPTH must be a power of two and at least 2");
  end
  if (STEP == 0) begin : g_bad_step
    $error("cnt_snapshot_mon: STEP must be non-zero");
  end

  logic pop;
  logic push;
  logic drop;

  // Handshake gating; clr priority is applied inside the FIFO and below.
  assign pop  = out_valid && out_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  snap_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .push_data (cnt_in),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .full      (full)
  );

  // Sticky overflow; a capture that coincides with clr is discarded silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef CNT_SNAPSHOT_STEP_CHECK_EN
  chk_state_e       chk_state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_exp;
  logic             step_err_q;

  // Expected value wraps naturally at WIDTH bits.
  assign prev_exp = prev + WIDTH'(STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_state  <= CHK_IDLE;
      prev       <= '0;
      step_err_q <= 1'b0;
    end else if (clr) begin
      chk_state  <= CHK_IDLE;
      step_err_q <= 1'b0;
    end else begin
      prev <= cnt_in;
      case (chk_state)
        CHK_IDLE: begin
          chk_state <= CHK_TRACK;
        end
        CHK_TRACK: begin
          if (cnt_in != prev_exp) begin
            step_err_q <= 1'b1;
            // Skip the next comparison so a single glitch reports once.
            chk_state  <= CHK_RESYNC;
          end
        end
        CHK_RESYNC: begin
          chk_state <= CHK_TRACK;
        end
        default: begin
          chk_state <= CHK_IDLE;
        end
      endcase
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule : cnt_snapshot_mon

// File: tb/tb_cnt_snapshot_mon.sv
// -----------------------------------------------------------------------------
// tb_cnt_snapshot_mon
// Self-checking bench for cnt_snapshot_mon. A queue-based reference model
// tracks FIFO contents and sticky flags; directed scenarios are followed by a
// randomized phase with occasional counter glitches and flushes.
// -----------------------------------------------------------------------------
module tb_cnt_snapshot_mon;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int STEP  = 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] cnt_in;
  logic             capture;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             overflow;
  logic             step_err;

  cnt_snapshot_mon #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_in    (cnt_in),
    .capture   (capture),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];      // snapshots in arrival order
  bit          m_ovf;
  bit          m_serr;
  bit          m_have_base;  // a baseline sample exists since reset/clr
  bit          m_skip;       // the sample after a violation is only a new baseline
  logic [31:0] m_last;

  function automatic void model_reset();
    mq.delete();
    m_ovf       = 1'b0;
    m_serr      = 1'b0;
    m_have_base = 1'b0;
    m_skip      = 1'b0;
    m_last      = '0;
  endfunction

  function automatic void model_edge();
    bit did_pop;
    if (clr) begin
      model_reset();
      return;
    end
    did_pop = (mq.size() != 0) && out_ready;
    if (did_pop) void'(mq.pop_front());
    if (capture) begin
      if (mq.size() < DEPTH) mq.push_back(cnt_in);
      else m_ovf = 1'b1;
    end
    if (!m_have_base) m_have_base = 1'b1;
    else if (m_skip) m_skip = 1'b0;
    else if (cnt_in != 32'(m_last + 32'(STEP))) begin
      m_serr = 1'b1;
      m_skip = 1'b1;
    end
    m_last = cnt_in;
  endfunction

  function automatic logic exp_step_err();
`ifdef CNT_SNAPSHOT_STEP_CHECK_EN
    return m_serr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("level",     32'(level),     32'(mq.size()));
    check("full",      32'(full),      32'(mq.size() == DEPTH));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("step_err",  32'(step_err),  32'(exp_step_err()));
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then
  // sample the DUT 1 ns after the edge.
  task automatic tick(input logic cap, input logic rdy, input logic c, input logic [31:0] v);
    capture   = cap;
    out_ready = rdy;
    clr       = c;
    cnt_in    = v;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  logic [31:0] last_out;
  logic [31:0] cv;

  initial begin
    rst_n     = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    cnt_in    = '0;
    model_reset();

    // Reset state
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data,       32'd0);
    check("rst_level", 32'(level),     32'd0);
    check("rst_flags", {29'd0, full, overflow, step_err}, 32'd0);
    #10 rst_n = 1'b1;

    // Counter from 0, capture at 3, then drain
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 2);
    tick(1, 0, 0, 3);
    check("tp1_valid", 32'(out_valid), 32'd1);
    check("tp1_data",  out_data,       32'd3);
    check("tp1_level", 32'(level),     32'd1);
    tick(0, 1, 0, 4);
    check("tp1_empty", 32'(out_valid), 32'd0);

    // Fill and overflow with 10..14, then drain in order
    tick(0, 0, 1, 9);
    for (int i = 10; i <= 14; i++) tick(1, 0, 0, 32'(i));
    check("tp2_full",  32'(full),     32'd1);
    check("tp2_level", 32'(level),    32'd4);
    check("tp2_ovf",   32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("tp2_drain", out_data, 32'(10 + k));
      tick(0, 1, 0, 32'(15 + k));
    end
    check("tp2_level0", 32'(level), 32'd0);

    // Full with simultaneous push and pop
    tick(0, 0, 1, 19);
    for (int i = 16; i <= 19; i++) tick(1, 0, 0, 32'(i));
    tick(1, 1, 0, 20);
    check("tp3_level", 32'(level),    32'd4);
    check("tp3_ovf",   32'(overflow), 32'd0);
    last_out = '0;
    for (int k = 0; k < 4; k++) begin
      last_out = out_data;
      tick(0, 1, 0, 32'(21 + k));
    end
    check("tp3_last", last_out, 32'd20);

    // Wrap is legal; a jump is reported once
    tick(0, 0, 1, 32'hFFFF_FFFD);
    tick(0, 0, 0, 32'hFFFF_FFFE);
    tick(0, 0, 0, 32'hFFFF_FFFF);
    tick(0, 0, 0, 32'h0000_0000);
    tick(0, 0, 0, 32'h0000_0001);
    check("tp4_wrap_ok", 32'(step_err), 32'd0);
    tick(0, 0, 0, 32'h0000_0005);
    check("tp4_jump", 32'(step_err), 32'(exp_step_err()));
    tick(0, 0, 0, 32'h0000_0006);
    tick(0, 0, 0, 32'h0000_0007);

    // clr together with capture, with level=3 and both sticky flags set
    tick(0, 0, 1, 100);
    for (int i = 101; i <= 105; i++) tick(1, 0, 0, 32'(i));
    tick(0, 1, 0, 106);
    tick(0, 0, 0, 200);
    tick(0, 0, 0, 201);
    check("tp5_pre_level", 32'(level), 32'd3);
    tick(1, 0, 1, 202);
    check("tp5_level", 32'(level),     32'd0);
    check("tp5_valid", 32'(out_valid), 32'd0);
    check("tp5_flags", {30'd0, overflow, step_err}, 32'd0);
    // Checker restarted in IDLE: the jump to 500 is only a baseline
    tick(0, 0, 0, 500);
    tick(0, 0, 0, 501);
    check("tp5_idle", 32'(step_err), 32'd0);

    // Asynchronous reset mid-drain
    tick(0, 0, 1, 502);
    tick(1, 0, 0, 503);
    tick(1, 0, 0, 504);
    tick(1, 0, 0, 505);
    tick(0, 1, 0, 506);
    out_ready = 1'b1;
    capture   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data",  out_data,       32'd0);
    check("ar_level", 32'(level),     32'd0);
    check("ar_flags", {29'd0, full, overflow, step_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 1);
    check("ar_first", out_data, 32'd1);
    tick(0, 1, 0, 2);

    // Randomized traffic
    cv = 3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) cv = $urandom();
      else if ($urandom_range(0, 199) == 0) cv = 32'hFFFF_FFF8;
      tick(1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 63) == 0),
           cv);
      cv = cv + 32'(STEP);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_cnt_snapshot_mon
